// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC unit and its branch target buffer.
package pc_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int BTB_ENTRIES_DEF = 16;
    localparam int BTB_IDX_DEF     = $clog2(BTB_ENTRIES_DEF);
    localparam int BTB_TAG_W_DEF   = XLEN_DEF - BTB_IDX_DEF - 2;

    // 2-bit saturating direction counter; MSB set means predict taken.
    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_STRONG_NT = 2'b00;
    localparam ctr_t CTR_WEAK_NT   = 2'b01;
    localparam ctr_t CTR_WEAK_T    = 2'b10;
    localparam ctr_t CTR_STRONG_T  = 2'b11;

    // One BTB line at the default geometry (32-bit PC, 16 entries).
    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_W_DEF-1:0] tag;
        logic [XLEN_DEF-1:0]      target;
        logic                     is_jump;
    } btb_entry_t;

    // Saturating counter step: increment on taken, decrement on not-taken.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken && ctr != CTR_STRONG_T) begin
            res = ctr + 2'd1;
        end else if (!taken && ctr != CTR_STRONG_NT) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_unit_btb_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters.
// Lookup is purely combinational on registered contents, so a same-cycle
// update to the looked-up index is only visible from the following cycle.
module btb_predictor
    import pc_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter bit PREDICT_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_branch,
    input  logic            upd_is_jump,
    input  logic            upd_is_jalr,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    generate
        if (PREDICT_EN) begin : g_btb
            logic [BTB_ENTRIES-1:0] valid_q;
            logic [BTB_ENTRIES-1:0] jump_q;
            ctr_t                   ctr_q    [BTB_ENTRIES];
            logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
            logic [XLEN-1:0]        target_q [BTB_ENTRIES];

            logic [IDX-1:0]   lk_idx;
            logic [IDX-1:0]   up_idx;
            logic [TAG_W-1:0] lk_tag;
            logic [TAG_W-1:0] up_tag;
            logic             lk_hit;
            logic             up_hit;
            logic             alloc_jal;
            logic             alloc_br;
            logic             train;
            logic             unused_lsb;

            assign lk_idx = lookup_pc[IDX+1:2];
            assign lk_tag = lookup_pc[XLEN-1:IDX+2];
            assign up_idx = upd_pc[IDX+1:2];
            assign up_tag = upd_pc[XLEN-1:IDX+2];
            assign unused_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

            assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
            assign pred_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
            assign pred_target = target_q[lk_idx];

            // JAL wins over other flags; JALR targets are data dependent and never cached.
            assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
            assign alloc_jal = upd_valid && upd_is_jump;
            assign alloc_br  = upd_valid && !upd_is_jump && !upd_is_jalr &&
                               upd_is_branch && upd_taken && !up_hit;
            assign train     = upd_valid && !upd_is_jump && !upd_is_jalr &&
                               upd_is_branch && up_hit;

            // Valid bits and counters: cleared to empty / weak not-taken on reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    for (int i = 0; i < BTB_ENTRIES; i++) begin
                        ctr_q[i] <= CTR_WEAK_NT;
                    end
                end else begin
                    if (alloc_jal) begin
                        valid_q[up_idx] <= 1'b1;
                    end else if (alloc_br) begin
                        valid_q[up_idx] <= 1'b1;
                        ctr_q[up_idx]   <= CTR_WEAK_T;
                    end else if (train) begin
                        ctr_q[up_idx]   <= ctr_next(ctr_q[up_idx], upd_taken);
                    end
                end
            end

            // Tag/target payload: only meaningful behind a valid bit, so left unreset.
            always_ff @(posedge clk) begin
                if (alloc_jal || alloc_br) begin
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= upd_target;
                    jump_q[up_idx]   <= alloc_jal;
                end
            end
        end else begin : g_static
            logic unused_in;

            assign pred_taken  = 1'b0;
            assign pred_target = '0;
            assign unused_in   = ^{clk, rst_n, lookup_pc, upd_valid, upd_pc, upd_is_branch,
                                   upd_is_jump, upd_is_jalr, upd_taken, upd_target};
        end
    endgenerate

endmodule

// File: rtl/pc_unit.sv
// Fetch PC unit: owns the fetch PC, predicts the next PC through the BTB,
// and redirects fetch when execute resolves a different next PC than the
// one that travelled down the pipe with the instruction.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter int              BTB_ENTRIES  = BTB_ENTRIES_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              PREDICT_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred_taken,
    output logic [XLEN-1:0] fetch_pred_next,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_is_jalr,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pred_next,
    output logic            redirect
);

    logic [XLEN-1:0] pc_q;
    logic            running_q;
    logic [XLEN-1:0] pred_target;
    logic            ex_flow_change;
    logic [XLEN-1:0] ex_resolved_target;
    logic [XLEN-1:0] actual_next;

    btb_predictor #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .PREDICT_EN  (PREDICT_EN)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_pc     (pc_q),
        .pred_taken    (fetch_pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (ex_valid),
        .upd_pc        (ex_pc),
        .upd_is_branch (ex_is_branch),
        .upd_is_jump   (ex_is_jump),
        .upd_is_jalr   (ex_is_jalr),
        .upd_taken     (ex_taken),
        .upd_target    (ex_resolved_target)
    );

    assign fetch_pc        = pc_q;
    assign fetch_pred_next = fetch_pred_taken ? pred_target : pc_q + XLEN'(4);

    // JALR targets have bit 0 forced low even if execute forgot to clear it.
    assign ex_resolved_target = ex_is_jalr ? {ex_target[XLEN-1:1], 1'b0} : ex_target;
    assign ex_flow_change     = ex_is_jump || ex_is_jalr || (ex_is_branch && ex_taken);
    assign actual_next        = ex_flow_change ? ex_resolved_target : ex_pc + XLEN'(4);
    assign redirect           = ex_valid && (actual_next != ex_pred_next);

    // The instruction at pc_q is on the wrong path while a redirect is pending.
    assign fetch_valid = running_q && rst_n && !redirect;

    // PC register: reset, then mispredict redirect, then accepted fetch, else stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_VECTOR;
            running_q <= 1'b0;
        end else begin
            running_q <= 1'b1;
            if (redirect) begin
                pc_q <= actual_next;
            end else if (fetch_valid && fetch_ready) begin
                pc_q <= fetch_pred_next;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: the bench plays execute, pushes each
// expected accepted fetch (pc, predicted next) into a scoreboard, and a
// negedge monitor pops and compares whenever the DUT hands out a fetch.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic [31:0] fetch_pred_next;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic        ex_is_jalr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_pred_next;
    logic        redirect;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] nxt;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   n_pushed   = 0;
    int   n_accepted = 0;

    pc_unit #(
        .XLEN         (32),
        .BTB_ENTRIES  (16),
        .RESET_VECTOR (32'h100),
        .PREDICT_EN   (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .fetch_pred_next  (fetch_pred_next),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_is_jalr       (ex_is_jalr),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_next     (ex_pred_next),
        .redirect         (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every accepted fetch must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && fetch_valid && fetch_ready) begin
            n_accepted++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("sb_fetch_pc", fetch_pc, e.pc);
                check_eq("sb_pred_next", fetch_pred_next, e.nxt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        ex_valid     = 1'b0;
        ex_pc        = '0;
        ex_is_branch = 1'b0;
        ex_is_jump   = 1'b0;
        ex_is_jalr   = 1'b0;
        ex_taken     = 1'b0;
        ex_target    = '0;
        ex_pred_next = '0;
    endtask

    task automatic ex_drive(input logic [31:0] pc, input logic br, input logic jal,
                            input logic jalr, input logic tkn, input logic [31:0] tgt,
                            input logic [31:0] pnext);
        ex_valid     = 1'b1;
        ex_pc        = pc;
        ex_is_branch = br;
        ex_is_jump   = jal;
        ex_is_jalr   = jalr;
        ex_taken     = tkn;
        ex_target    = tgt;
        ex_pred_next = pnext;
    endtask

    // Force fetch to addr with a flag-less resolved instruction at addr-4.
    task automatic redir_to(input logic [31:0] addr);
        fetch_ready = 1'b0;
        ex_drive(addr - 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, addr ^ 32'h10);
        step();
        ex_clear();
        check_eq("redir_pc", fetch_pc, addr);
    endtask

    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] nxt);
        exp_t e;
        e.pc  = pc;
        e.nxt = nxt;
        sb.push_back(e);
        n_pushed++;
        fetch_ready = 1'b1;
        step();
        fetch_ready = 1'b0;
        check_eq("fetch_adv_pc", fetch_pc, nxt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        fetch_ready = 1'b0;
        ex_clear();
        step();
        step();
        check_eq("rst_pc", fetch_pc, 32'h100);
        check_eq("rst_fetch_valid", fetch_valid, 1'b0);

        // Reset release and sequential fetch
        rst_n = 1'b1;
        step();
        check_eq("post_rst_valid", fetch_valid, 1'b1);
        check_eq("post_rst_pc", fetch_pc, 32'h100);
        fetch_one(32'h100, 32'h104);
        fetch_one(32'h104, 32'h108);

        // Stall holds PC
        repeat (3) step();
        check_eq("stall_pc", fetch_pc, 32'h108);
        check_eq("stall_valid", fetch_valid, 1'b1);
        fetch_one(32'h108, 32'h10C);

        // Cold taken branch: redirect, fetch_valid dropped even with ready high
        fetch_ready = 1'b1;
        ex_drive(32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h110);
        #1;
        check_eq("cold_redirect", redirect, 1'b1);
        check_eq("cold_fv_low", fetch_valid, 1'b0);
        step();
        ex_clear();
        fetch_ready = 1'b0;
        check_eq("cold_new_pc", fetch_pc, 32'h200);
        fetch_one(32'h200, 32'h204);
        redir_to(32'h10C);
        check_eq("warm_pred_taken", fetch_pred_taken, 1'b1);
        fetch_one(32'h10C, 32'h200);

        // Counter walk 10 -> 01 -> 00 -> 01
        ex_drive(32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h200);
        #1;
        check_eq("nt1_redirect", redirect, 1'b1);
        step();
        ex_clear();
        check_eq("nt1_pc", fetch_pc, 32'h110);
        ex_drive(32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h110);
        #1;
        check_eq("nt2_redirect", redirect, 1'b0);
        step();
        ex_drive(32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h200);
        #1;
        check_eq("t1_redirect", redirect, 1'b0);
        step();
        ex_clear();
        redir_to(32'h10C);
        check_eq("ctr01_pred_taken", fetch_pred_taken, 1'b0);
        fetch_one(32'h10C, 32'h110);
        ex_drive(32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h110);
        #1;
        check_eq("t2_redirect", redirect, 1'b1);
        step();
        ex_clear();
        redir_to(32'h10C);
        fetch_one(32'h10C, 32'h200);

        // JALR: bit0 cleared, redirect, never cached
        ex_drive(32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h405, 32'h304);
        #1;
        check_eq("jalr_redirect", redirect, 1'b1);
        step();
        ex_clear();
        check_eq("jalr_pc", fetch_pc, 32'h404);
        redir_to(32'h300);
        fetch_one(32'h300, 32'h304);

        // JAL allocation predicts taken regardless of counter
        ex_drive(32'h140, 1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h144);
        step();
        ex_clear();
        check_eq("jal_pc", fetch_pc, 32'h500);
        redir_to(32'h140);
        check_eq("jal_pred_taken", fetch_pred_taken, 1'b1);
        fetch_one(32'h140, 32'h500);

        // Wrap and same-cycle update on the looked-up index
        redir_to(32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h0);
        redir_to(32'hFFFF_FFFC);
        fetch_ready = 1'b0;
        ex_drive(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h0);
        #1;
        check_eq("same_idx_pred_next", fetch_pred_next, 32'h0);
        check_eq("same_idx_pred_taken", fetch_pred_taken, 1'b0);
        check_eq("same_idx_redirect", redirect, 1'b1);
        check_eq("same_idx_fv_low", fetch_valid, 1'b0);
        step();
        ex_clear();
        check_eq("same_idx_pc", fetch_pc, 32'h800);
        redir_to(32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h800);

        step();
        check_eq("sb_drained", sb.size(), 0);
        check_eq("fetch_count", n_accepted, n_pushed);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
